// File: rtl/membus_arbiter_pkg.sv
// Shared encodings for the CPU/DMA memory-bus arbiter: FSM states and bus-owner values.
package membus_arbiter_pkg;

   typedef enum logic [1:0] {
      CPU     = 2'd0,
      HOLD    = 2'd1,
      DMA     = 2'd2,
      RECOVER = 2'd3
   } arb_state_e;

   localparam logic OWNER_CPU = 1'b0;
   localparam logic OWNER_DMA = 1'b1;

   // Pipeline stages 0/1 stay frozen while a DMA request waits or is served.
   function automatic logic holds_pipeline(input arb_state_e st);
      return (st == HOLD) || (st == DMA);
   endfunction

endpackage

// File: rtl/membus_arbiter_if.sv
// Request/grant signals between the CPU pipeline, the DMA master and the bus arbiter.
interface membus_arbiter_if #(
   parameter int CNT_W = 5
);
   logic             cpu_bus_req;
   logic             cpu_fetch;
   logic             dma_req;
   logic             dma_last;
   logic             cpu_hold;
   logic             dma_grant;
   logic             bus_owner;
   logic [CNT_W-1:0] burst_count;
   logic             dma_preempted;

   modport master (
      output cpu_bus_req, cpu_fetch, dma_req, dma_last,
      input  cpu_hold, dma_grant, bus_owner, burst_count, dma_preempted
   );

   modport slave (
      input  cpu_bus_req, cpu_fetch, dma_req, dma_last,
      output cpu_hold, dma_grant, bus_owner, burst_count, dma_preempted
   );
endinterface

// File: rtl/membus_arbiter_bounded_counter.sv
// Saturating up/down counter with synchronous clear and load; priority clr > load > inc > dec.
module bounded_counter #(
   parameter int W   = 4,
   parameter int MAX = 15
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         inc,
   input  logic         dec,
   output logic [W-1:0] count
);

   // Counter register: holds at MAX on increment and at zero on decrement.
   always_ff @(posedge clk) begin
      if (reset) begin
         count <= {W{1'b0}};
      end else if (clr) begin
         count <= {W{1'b0}};
      end else if (load) begin
         count <= load_val;
      end else if (inc && (count != W'(MAX))) begin
         count <= count + W'(1'b1);
      end else if (dec && (count != {W{1'b0}})) begin
         count <= count - W'(1'b1);
      end else begin
         count <= count;
      end
   end

endmodule

// File: rtl/membus_arbiter.sv
// Arbitrates the address/memory bus between the CPU pipeline (default owner) and one DMA master,
// with a bounded DMA burst followed by a guaranteed CPU-owned recovery window.
module membus_arbiter
   import membus_arbiter_pkg::*;
#(
   parameter int MAX_BURST = 16,
   parameter int CPU_MIN   = 4,
   parameter int CNT_W     = $clog2(MAX_BURST + 1)
) (
   input logic             clk,
   input logic             reset,
   membus_arbiter_if.slave bus
);

   localparam int WIN_W = $clog2(CPU_MIN + 1);

   arb_state_e       state_r;
   arb_state_e       next_state_s;
   logic             dma_exit_s;
   logic             preempt_end_s;
   logic             at_limit_s;
   logic             burst_clr_s;
   logic             burst_inc_s;
   logic             win_load_s;
   logic             win_dec_s;
   logic [CNT_W-1:0] burst_count_s;
   logic [WIN_W-1:0] win_count_s;
   logic             cpu_hold_r;
   logic             dma_grant_r;
   logic             bus_owner_r;
   logic             dma_preempted_r;
   logic             unused_fetch_s;

   // Fetch activity is informational only; it never delays a DMA request.
   assign unused_fetch_s = bus.cpu_fetch;

   assign at_limit_s = (burst_count_s == CNT_W'(MAX_BURST - 1));

   // Next-state logic and DMA exit classification.
   always_comb begin
      next_state_s  = state_r;
      dma_exit_s    = 1'b0;
      preempt_end_s = 1'b0;
      case (state_r)
         CPU: begin
            if (bus.dma_req) begin
               next_state_s = HOLD;
            end else begin
               next_state_s = CPU;
            end
         end
         HOLD: begin
            if (!bus.dma_req) begin
               next_state_s = CPU;
            end else if (!bus.cpu_bus_req) begin
               next_state_s = DMA;
            end else begin
               next_state_s = HOLD;
            end
         end
         DMA: begin
            // dma_last wins over the burst limit, so a coincident end is not a preemption.
            if (!bus.dma_req) begin
               dma_exit_s = 1'b1;
            end else if (bus.dma_last) begin
               dma_exit_s = 1'b1;
            end else if (at_limit_s) begin
               dma_exit_s    = 1'b1;
               preempt_end_s = 1'b1;
            end else begin
               dma_exit_s = 1'b0;
            end
            if (dma_exit_s) begin
               next_state_s = RECOVER;
            end else begin
               next_state_s = DMA;
            end
         end
         RECOVER: begin
            if (win_count_s == {WIN_W{1'b0}}) begin
               next_state_s = CPU;
            end else begin
               next_state_s = RECOVER;
            end
         end
         default: begin
            next_state_s = CPU;
         end
      endcase
   end

   // Counter controls: the final transfer's count is visible in the first recovery cycle, then cleared.
   always_comb begin
      burst_clr_s = (state_r == RECOVER);
      burst_inc_s = (state_r == DMA) && bus.dma_req;
      win_load_s  = (state_r == DMA) && dma_exit_s;
      win_dec_s   = (state_r == RECOVER);
   end

   bounded_counter #(
      .W   (CNT_W),
      .MAX (MAX_BURST)
   ) u_burst_cnt (
      .clk      (clk),
      .reset    (reset),
      .clr      (burst_clr_s),
      .load     (1'b0),
      .load_val ({CNT_W{1'b0}}),
      .inc      (burst_inc_s),
      .dec      (1'b0),
      .count    (burst_count_s)
   );

   bounded_counter #(
      .W   (WIN_W),
      .MAX (CPU_MIN)
   ) u_win_cnt (
      .clk      (clk),
      .reset    (reset),
      .clr      (1'b0),
      .load     (win_load_s),
      .load_val (WIN_W'(CPU_MIN - 1)),
      .inc      (1'b0),
      .dec      (win_dec_s),
      .count    (win_count_s)
   );

   // State register with outputs registered from the next state, so they track state_r exactly.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r         <= CPU;
         cpu_hold_r      <= 1'b0;
         dma_grant_r     <= 1'b0;
         bus_owner_r     <= OWNER_CPU;
         dma_preempted_r <= 1'b0;
      end else begin
         state_r         <= next_state_s;
         cpu_hold_r      <= holds_pipeline(next_state_s);
         dma_grant_r     <= (next_state_s == DMA);
         bus_owner_r     <= (next_state_s == DMA) ? OWNER_DMA : OWNER_CPU;
         dma_preempted_r <= preempt_end_s;
      end
   end

   assign bus.cpu_hold      = cpu_hold_r;
   assign bus.dma_grant     = dma_grant_r;
   assign bus.bus_owner     = bus_owner_r;
   assign bus.burst_count   = burst_count_s;
   assign bus.dma_preempted = dma_preempted_r;

endmodule
